ov5640_capture: RTL and testbench

//  Camera-side capture stage between the OV5640 DVP pins and the SDRAM write-FIFO port.
//  - Pairs 8-bit pclk bytes into 16-bit RGB565 words, high byte first.
//  - Discards the settling frames that follow camera init.
//  - Aligns capture to a frame boundary.
//  - Caps writes at exactly H_PIXEL*V_PIXEL words per frame, so the SDRAM address window is never overrun.

---
 rtl/ov5640_pkg.sv | 21 ++
 rtl/ov5640_capture_sync_2ff.sv | 29 ++
 rtl/ov5640_capture.sv | 177 +++++++++++++++++
 tb/tb_ov5640_capture.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// ov5640_pkg
// Shared types and default geometry for the OV5640 capture stage.
//   state_e       : capture FSM states
//   DEF_H_PIXEL   : default 16-bit words written per line
//   DEF_V_PIXEL   : default lines written per frame
//   DEF_FRAME_WAIT: default whole frames discarded after init
//   DEF_CNT_W     : default pixel/line/frame counter width
package ov5640_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int DEF_H_PIXEL    = 640;
    localparam int DEF_V_PIXEL    = 480;
    localparam int DEF_FRAME_WAIT = 10;
    localparam int DEF_CNT_W      = 12;

endpackage

// File: rtl/ov5640_capture_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single level signal entering the pclk domain.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous level input
//   q_o    : synchronised level output (two clk_i cycles of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ov5640_capture.sv
// ov5640_capture
// Capture stage between the OV5640 DVP pins and the SDRAM write-FIFO port.
// Pairs camera bytes into RGB565 words (high byte first), discards the
// settling frames after init, aligns capture to a frame boundary and caps
// writes at H_PIXEL*V_PIXEL words per frame.
//   ov5640_pclk     : sole clock, all logic on rising edge
//   sys_rst_n       : asynchronous active-low reset
//   sys_init_done   : init complete (foreign domain, synchronised here)
//   ov5640_vsync    : frame sync pulse preceding each frame
//   ov5640_href     : line valid
//   ov5640_data     : camera byte
//   ov5640_wr_en    : one-cycle write strobe
//   ov5640_data_out : RGB565 word, valid with ov5640_wr_en
//   frame_start     : one-cycle pulse at each captured frame start
//   fmt_err         : sticky line/frame size mismatch flag
module ov5640_capture
    import ov5640_pkg::*;
#(
    parameter int H_PIXEL    = DEF_H_PIXEL,
    parameter int V_PIXEL    = DEF_V_PIXEL,
    parameter int FRAME_WAIT = DEF_FRAME_WAIT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic        ov5640_pclk,
    input  logic        sys_rst_n,
    input  logic        sys_init_done,
    input  logic        ov5640_vsync,
    input  logic        ov5640_href,
    input  logic [7:0]  ov5640_data,
    output logic        ov5640_wr_en,
    output logic [15:0] ov5640_data_out,
    output logic        frame_start,
    output logic        fmt_err
);

    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_PIXEL);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_PIXEL);
    localparam logic [CNT_W-1:0] FW_MAX = CNT_W'(FRAME_WAIT);

    logic init_s;

    sync_2ff u_sync_init (
        .clk_i  (ov5640_pclk),
        .rst_ni (sys_rst_n),
        .d_i    (sys_init_done),
        .q_o    (init_s)
    );

    // Input pipeline: one register stage, plus a second stage on the
    // sync signals for edge detection.
    logic        vsync_q, vsync_q2;
    logic        href_q, href_q2;
    logic [7:0]  data_q;

    state_e      state_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic        byte_flag_q;
    logic [7:0]  hi_q;
    logic        wr_en_q;
    logic [15:0] data_out_q;
    logic        frame_start_q;
    logic        fmt_err_q;

    logic vs_rise;
    logic href_fall;

    assign vs_rise   = vsync_q & ~vsync_q2;
    assign href_fall = href_q2 & ~href_q;

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_q       <= 1'b0;
            vsync_q2      <= 1'b0;
            href_q        <= 1'b0;
            href_q2       <= 1'b0;
            data_q        <= '0;
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            byte_flag_q   <= 1'b0;
            hi_q          <= '0;
            wr_en_q       <= 1'b0;
            data_out_q    <= '0;
            frame_start_q <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            vsync_q  <= ov5640_vsync;
            vsync_q2 <= vsync_q;
            href_q   <= ov5640_href;
            href_q2  <= href_q;
            data_q   <= ov5640_data;

            // Strobes are single-cycle unless re-asserted below.
            wr_en_q       <= 1'b0;
            frame_start_q <= 1'b0;

            if (!init_s) begin
                // Losing init overrides everything, including a coincident
                // vs_rise; any half-assembled word is dropped.
                state_q     <= IDLE;
                frame_cnt_q <= '0;
                pix_cnt_q   <= '0;
                line_cnt_q  <= '0;
                byte_flag_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q     <= SKIP;
                        frame_cnt_q <= '0;
                    end

                    SKIP: begin
                        if (vs_rise) begin
                            if (frame_cnt_q == FW_MAX) begin
                                // Entry edge: no size check, nothing captured yet.
                                state_q       <= CAPTURE;
                                frame_start_q <= 1'b1;
                                line_cnt_q    <= '0;
                                pix_cnt_q     <= '0;
                                byte_flag_q   <= 1'b0;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 1'b1;
                            end
                        end
                    end

                    CAPTURE: begin
                        if (vs_rise) begin
                            // Frame reset takes priority over a coincident href fall.
                            if (line_cnt_q != V_MAX) begin
                                fmt_err_q <= 1'b1;
                            end
                            frame_start_q <= 1'b1;
                            line_cnt_q    <= '0;
                            pix_cnt_q     <= '0;
                            byte_flag_q   <= 1'b0;
                        end else if (href_q) begin
                            byte_flag_q <= ~byte_flag_q;
                            if (!byte_flag_q) begin
                                hi_q <= data_q;
                            end else if (pix_cnt_q < H_MAX) begin
                                pix_cnt_q <= pix_cnt_q + 1'b1;
                                if (line_cnt_q < V_MAX) begin
                                    wr_en_q    <= 1'b1;
                                    data_out_q <= {hi_q, data_q};
                                end
                            end
                        end else begin
                            // Trailing odd byte is simply forgotten here.
                            byte_flag_q <= 1'b0;
                            if (href_fall) begin
                                if ((pix_cnt_q != H_MAX) && (line_cnt_q < V_MAX)) begin
                                    fmt_err_q <= 1'b1;
                                end
                                if (line_cnt_q < V_MAX) begin
                                    line_cnt_q <= line_cnt_q + 1'b1;
                                end
                                pix_cnt_q <= '0;
                            end
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ov5640_wr_en    = wr_en_q;
    assign ov5640_data_out = data_out_q;
    assign frame_start     = frame_start_q;
    assign fmt_err         = fmt_err_q;

endmodule

// File: tb/tb_ov5640_capture.sv
module tb_ov5640_capture;
    import ov5640_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int FW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        wr_en;
    logic [15:0] dout;
    logic        fs;
    logic        err;

    always #5 clk = ~clk;

    ov5640_capture #(
        .H_PIXEL    (H),
        .V_PIXEL    (V),
        .FRAME_WAIT (FW),
        .CNT_W      (12)
    ) dut (
        .ov5640_pclk     (clk),
        .sys_rst_n       (rst_n),
        .sys_init_done   (init),
        .ov5640_vsync    (vsync),
        .ov5640_href     (href),
        .ov5640_data     (data),
        .ov5640_wr_en    (wr_en),
        .ov5640_data_out (dout),
        .frame_start     (fs),
        .fmt_err         (err)
    );

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int fs_cnt = 0;
    bit sb_on = 1'b1;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    typedef struct {
        int cap;      // captured frames before the closing vsync
        int nbytes;   // bytes per line
        int nlines;   // lines per frame
        int exp_str;  // expected strobes in total
        bit chk_err;  // whether fmt_err is compared
        bit exp_err;  // expected fmt_err
    } rec_t;

    rec_t recs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            strobes++;
            if (sb_on) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe got=%h required=none", dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (dout !== exp_w) begin
                        bad++;
                        $display("FAIL strobe_data got=%h required=%h", dout, exp_w);
                    end
                end
            end
        end
        if (rst_n && fs) fs_cnt++;
    end

    function automatic logic [7:0] bval(input int l, input int i);
        return 8'((l * 37) + (i * 11) + 3);
    endfunction

    task automatic send_vsync();
        @(negedge clk); vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Drives one line; when cap is set, pushes the words a correct capture
    // stage must write (first H whole words of lines 0..V-1).
    task automatic send_line(input int nb, input int lidx, input bit cap);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            href = 1'b1;
            data = bval(lidx, i);
            if (cap && (i % 2 == 1) && (i / 2 < H) && (lidx < V))
                exp_q.push_back({bval(lidx, i - 1), bval(lidx, i)});
        end
        @(negedge clk);
        href = 1'b0;
        data = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        init = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        strobes = 0;
        fs_cnt = 0;
    endtask

    task automatic start_capture();
        do_reset();
        init = 1'b1;
        repeat (5) @(negedge clk);
        for (int f = 0; f <= FW; f++) send_vsync();
        chk("entry_frame_start", fs_cnt, 1);
    endtask

    initial begin
        int s0;
        bit drop_ok;

        recs[0] = '{2, 2*H,     V,     2*H*V,     1'b1, 1'b0};
        recs[1] = '{1, 2*H + 4, V,     H*V,       1'b0, 1'b0};
        recs[2] = '{1, 2*H - 1, V,     (H-1)*V,   1'b1, 1'b1};
        recs[3] = '{1, 2*H,     V + 2, H*V,       1'b0, 1'b0};
        recs[4] = '{1, 2*H,     V - 1, H*(V-1),   1'b1, 1'b1};
        recs[5] = '{1, 2,       1,     1,         1'b1, 1'b1};

        #1;
        chk("reset_outputs", {wr_en, fs, err, dout}, 0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));

        for (int r = 0; r < 6; r++) begin
            do_reset();
            init = 1'b1;
            repeat (5) @(negedge clk);
            for (int f = 0; f < FW + recs[r].cap; f++) begin
                send_vsync();
                for (int l = 0; l < recs[r].nlines; l++)
                    send_line(recs[r].nbytes, l, f >= FW);
            end
            send_vsync();
            $display("rec %0d: strobes=%0d frame_starts=%0d fmt_err=%0b", r, strobes, fs_cnt, err);
            chk($sformatf("rec%0d_strobes", r), strobes, recs[r].exp_str);
            chk($sformatf("rec%0d_frame_start", r), fs_cnt, recs[r].cap + 1);
            chk($sformatf("rec%0d_drained", r), exp_q.size(), 0);
            if (recs[r].chk_err)
                chk($sformatf("rec%0d_fmt_err", r), err, recs[r].exp_err);
        end

        // Two-byte word and its exact strobe cycle.
        start_capture();
        chk("pair_fmt_err_clear", err, 0);
        @(negedge clk); href = 1'b1; data = 8'hF8;
        exp_q.push_back(16'hF81F);
        @(negedge clk); data = 8'h1F;
        @(negedge clk); href = 1'b0; data = 8'h00;
        chk("pair_no_early_strobe", wr_en, 0);
        @(negedge clk);
        chk("pair_strobe", wr_en, 1);
        chk("pair_data", dout, 32'hF81F);
        repeat (3) @(negedge clk);
        $display("pair: strobes=%0d", strobes);
        chk("pair_single", strobes, 1);

        // Oversized line, short odd line, then too many lines.
        start_capture();
        send_line(2*H + 4, 0, 1'b1);
        send_line(2*H - 1, 1, 1'b1);
        for (int l = 2; l < V + 2; l++) send_line(2*H, l, 1'b1);
        $display("bad frame: strobes=%0d fmt_err=%0b", strobes, err);
        chk("badframe_strobes", strobes, H + (H - 1) + (V - 2) * H);
        chk("badframe_fmt_err", err, 1);
        s0 = strobes;
        send_vsync();
        chk("badframe_next_start", fs_cnt, 2);
        send_line(2*H, 0, 1'b1);
        chk("badframe_recount", strobes - s0, H);
        chk("badframe_drained", exp_q.size(), 0);

        // Init drops mid-line.
        start_capture();
        sb_on = 1'b0;
        drop_ok = 1'b1;
        for (int i = 0; i < 2*H; i++) begin
            @(negedge clk);
            if (i >= 8 && wr_en) drop_ok = 1'b0;
            href = 1'b1;
            data = bval(0, i);
            if (i == 5) init = 1'b0;
        end
        @(negedge clk); href = 1'b0;
        repeat (2) @(negedge clk);
        $display("init drop: wr_en quiet=%0b", drop_ok);
        chk("drop_wr_en_low", drop_ok, 1);
        chk("drop_state_idle", 32'(dut.state_q), 32'(IDLE));
        init = 1'b1;
        repeat (5) @(negedge clk);
        fs_cnt = 0;
        strobes = 0;
        sb_on = 1'b1;
        for (int f = 0; f < FW; f++) begin
            send_vsync();
            send_line(2*H, 0, 1'b0);
        end
        chk("reinit_skip_no_start", fs_cnt, 0);
        chk("reinit_skip_no_strobe", strobes, 0);
        send_vsync();
        chk("reinit_start", fs_cnt, 1);
        send_line(2*H, 0, 1'b1);
        chk("reinit_line", strobes, H);

        // Asynchronous reset mid-word.
        start_capture();
        @(negedge clk); href = 1'b1; data = 8'hA5;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {wr_en, fs, err, dout}, 0);
        chk("async_reset_state", 32'(dut.state_q), 32'(IDLE));
        s0 = strobes;
        @(negedge clk); data = 8'h5A;
        @(negedge clk); rst_n = 1'b1; data = 8'h33;
        #1;
        chk("release_state", 32'(dut.state_q), 32'(IDLE));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); data = 8'(i);
        end
        @(negedge clk); href = 1'b0;
        repeat (4) @(negedge clk);
        chk("release_no_strobe", strobes - s0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
